// File: rtl/reg_fifo_pkg.sv
// Shared definitions for the register-based FIFO.
//   FIFO_MODE_FWFT / FIFO_MODE_REG : values for the FWFT parameter
//   cntWidth()                     : width needed to hold an occupancy of 0..depth
package reg_fifo_pkg;

  localparam int FIFO_MODE_REG  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  // Occupancy must reach DEPTH itself, hence one bit above the address width.
  function automatic int cntWidth(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/reg_fifo_ctrl.sv
// Control path of the register FIFO: accept decisions, pointers, occupancy,
// status flags, sticky error flags and the high-water monitor.
// Ports:
//   clockCore, resetCore          : clock, synchronous active-high reset
//   flush, push, pop, errClear    : requests
//   almostFull/EmptyThreshold     : live occupancy thresholds
//   wrEn, wrAddr, rdAddr, popAcc  : storage control towards the top level
//   full, empty, almost*Flag      : status decoded from registered count
//   fifoDepth, highWater          : occupancy and its running maximum
//   overrun, underrun             : sticky error flags
module reg_fifo_ctrl
  import reg_fifo_pkg::*;
#(
  parameter  int DEPTH  = 8,
  localparam int CNT_W  = cntWidth(DEPTH),
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clockCore,
  input  logic              resetCore,
  input  logic              flush,
  input  logic              push,
  input  logic              pop,
  input  logic              errClear,
  input  logic [CNT_W-1:0]  almostFullThreshold,
  input  logic [CNT_W-1:0]  almostEmptyThreshold,
  output logic              wrEn,
  output logic [ADDR_W-1:0] wrAddr,
  output logic [ADDR_W-1:0] rdAddr,
  output logic              popAcc,
  output logic              full,
  output logic              empty,
  output logic              almostFullFlag,
  output logic              almostEmptyFlag,
  output logic [CNT_W-1:0]  fifoDepth,
  output logic [CNT_W-1:0]  highWater,
  output logic              overrun,
  output logic              underrun
);

  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] wrPtr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  countNext;
  logic [CNT_W-1:0]  hwBase;
  logic              pushAcc;
  logic              overrunSet;
  logic              underrunSet;

  assign empty           = (count == '0);
  assign full            = (count == FULL_CNT);
  assign almostFullFlag  = (count >= almostFullThreshold);
  assign almostEmptyFlag = (count <= almostEmptyThreshold);
  assign fifoDepth       = count;
  assign wrEn            = pushAcc;
  assign wrAddr          = wrPtr;
  assign rdAddr          = rdPtr;

  // Flush masks both requests, so it can neither move data nor raise errors.
  // A push into a full FIFO is still taken when a pop frees the slot.
  always_comb begin
    popAcc      = !flush && pop && !empty;
    pushAcc     = !flush && push && (!full || popAcc);
    overrunSet  = !flush && push && !pushAcc;
    underrunSet = !flush && pop && empty;
    countNext   = count;
    if (flush) begin
      countNext = '0;
    end else begin
      case ({pushAcc, popAcc})
        2'b10:   countNext = count + CNT_W'(1);
        2'b01:   countNext = count - CNT_W'(1);
        default: countNext = count;
      endcase
    end
    // errClear restarts the monitor from the post-edge occupancy.
    hwBase = errClear ? '0 : highWater;
  end

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      rdPtr     <= '0;
      wrPtr     <= '0;
      count     <= '0;
      highWater <= '0;
      overrun   <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      if (flush) begin
        rdPtr <= '0;
        wrPtr <= '0;
      end else begin
        if (popAcc)  rdPtr <= rdPtr + ADDR_W'(1);
        if (pushAcc) wrPtr <= wrPtr + ADDR_W'(1);
      end
      count     <= countNext;
      highWater <= (countNext > hwBase) ? countNext : hwBase;
      // A new error in the clearing cycle survives the clear.
      overrun   <= overrunSet  | (overrun  & ~errClear);
      underrun  <= underrunSet | (underrun & ~errClear);
    end
  end

endmodule

// File: rtl/reg_fifo_param.sv
// Parametrised register-based synchronous FIFO.
// Holds the storage array and selects the output mode; all control lives in
// reg_fifo_ctrl.
// Ports:
//   clockCore, resetCore       : clock, synchronous active-high reset
//   flush, push, dataIn, pop   : requests and write data
//   dataOut, dataOutValid      : read data (FWFT head or registered pop result)
//   full, empty, almost*Flag   : status
//   almost*Threshold           : live thresholds, unsigned
//   fifoDepth, highWater       : occupancy and its maximum since reset/errClear
//   overrun, underrun, errClear: sticky errors and their clear
module reg_fifo_param
  import reg_fifo_pkg::*;
#(
  parameter  int DEPTH = 8,
  parameter  int WIDTH = 60,
  parameter  int FWFT  = FIFO_MODE_FWFT,
  localparam int CNT_W = cntWidth(DEPTH)
) (
  input  logic             clockCore,
  input  logic             resetCore,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pop,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataOutValid,
  output logic             full,
  output logic             empty,
  input  logic [CNT_W-1:0] almostFullThreshold,
  input  logic [CNT_W-1:0] almostEmptyThreshold,
  output logic             almostFullFlag,
  output logic             almostEmptyFlag,
  output logic [CNT_W-1:0] fifoDepth,
  output logic [CNT_W-1:0] highWater,
  output logic             overrun,
  output logic             underrun,
  input  logic             errClear
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic              wrEn;
  logic [ADDR_W-1:0] wrAddr;
  logic [ADDR_W-1:0] rdAddr;
  logic              popAcc;

  reg_fifo_ctrl #(
    .DEPTH(DEPTH)
  ) uCtrl (
    .clockCore            (clockCore),
    .resetCore            (resetCore),
    .flush                (flush),
    .push                 (push),
    .pop                  (pop),
    .errClear             (errClear),
    .almostFullThreshold  (almostFullThreshold),
    .almostEmptyThreshold (almostEmptyThreshold),
    .wrEn                 (wrEn),
    .wrAddr               (wrAddr),
    .rdAddr               (rdAddr),
    .popAcc               (popAcc),
    .full                 (full),
    .empty                (empty),
    .almostFullFlag       (almostFullFlag),
    .almostEmptyFlag      (almostEmptyFlag),
    .fifoDepth            (fifoDepth),
    .highWater            (highWater),
    .overrun              (overrun),
    .underrun             (underrun)
  );

  always_ff @(posedge clockCore) begin
    if (resetCore) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wrEn) begin
      mem[wrAddr] <= dataIn;
    end
  end

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : genFwft
      // The head slot is presented directly; the pop strobe is not needed.
      logic unusedPopAcc;
      assign unusedPopAcc = popAcc;
      assign dataOut      = mem[rdAddr];
      assign dataOutValid = !empty;
    end else begin : genReg
      always_ff @(posedge clockCore) begin
        if (resetCore) begin
          dataOut      <= '0;
          dataOutValid <= 1'b0;
        end else begin
          // popAcc is already masked by flush, so a flush also drops valid.
          dataOutValid <= popAcc;
          if (popAcc) dataOut <= mem[rdAddr];
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_fifo_param.sv
module tb_reg_fifo_param;

  localparam int DEPTH = 8;
  localparam int WIDTH = 60;
  localparam int CNT_W = 4;

  logic             clockCore = 1'b0;
  logic             resetCore = 1'b1;
  logic             flush = 1'b0;
  logic             push = 1'b0;
  logic             pop = 1'b0;
  logic             errClear = 1'b0;
  logic [WIDTH-1:0] dataIn = '0;
  logic [CNT_W-1:0] afThr = 4'd6;
  logic [CNT_W-1:0] aeThr = 4'd2;

  logic [WIDTH-1:0] fwDataOut, rgDataOut;
  logic             fwValid, rgValid, fwFull, rgFull, fwEmpty, rgEmpty;
  logic             fwAf, rgAf, fwAe, rgAe, fwOv, rgOv, fwUn, rgUn;
  logic [CNT_W-1:0] fwDepth, rgDepth, fwHw, rgHw;

  int unsigned nCompared   = 0;
  int unsigned nMismatched = 0;

  // Bench model
  logic [WIDTH-1:0] modelQ[$];
  logic [WIDTH-1:0] regExp[$];
  logic [WIDTH-1:0] lastReg = '0;
  int unsigned      mHw = 0;
  logic             mOv = 1'b0;
  logic             mUn = 1'b0;
  logic             mValid = 1'b0;

  always #5 clockCore = ~clockCore;

  reg_fifo_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1)) dutFwft (
    .clockCore(clockCore), .resetCore(resetCore), .flush(flush), .push(push),
    .dataIn(dataIn), .pop(pop), .dataOut(fwDataOut), .dataOutValid(fwValid),
    .full(fwFull), .empty(fwEmpty), .almostFullThreshold(afThr),
    .almostEmptyThreshold(aeThr), .almostFullFlag(fwAf), .almostEmptyFlag(fwAe),
    .fifoDepth(fwDepth), .highWater(fwHw), .overrun(fwOv), .underrun(fwUn),
    .errClear(errClear)
  );

  reg_fifo_param #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0)) dutReg (
    .clockCore(clockCore), .resetCore(resetCore), .flush(flush), .push(push),
    .dataIn(dataIn), .pop(pop), .dataOut(rgDataOut), .dataOutValid(rgValid),
    .full(rgFull), .empty(rgEmpty), .almostFullThreshold(afThr),
    .almostEmptyThreshold(aeThr), .almostFullFlag(rgAf), .almostEmptyFlag(rgAe),
    .fifoDepth(rgDepth), .highWater(rgHw), .overrun(rgOv), .underrun(rgUn),
    .errClear(errClear)
  );

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nCompared++;
    if (got !== exp) begin
      nMismatched++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic checkOutputs();
    int unsigned sz;
    sz = modelQ.size();
    checkVal("depth", 64'(fwDepth), 64'(sz));
    checkVal("empty", 64'(fwEmpty), 64'(sz == 0));
    checkVal("full", 64'(fwFull), 64'(sz == DEPTH));
    checkVal("fwValid", 64'(fwValid), 64'(sz != 0));
    checkVal("overrun", 64'(fwOv), 64'(mOv));
    checkVal("underrun", 64'(fwUn), 64'(mUn));
    checkVal("highWater", 64'(fwHw), 64'(mHw));
    checkVal("almostFull", 64'(fwAf), 64'(sz >= 32'(afThr)));
    checkVal("almostEmpty", 64'(fwAe), 64'(sz <= 32'(aeThr)));
    if (sz != 0) checkVal("fwHead", 64'(fwDataOut), 64'(modelQ[0]));
    checkVal("regDepth", 64'(rgDepth), 64'(sz));
    checkVal("regValid", 64'(rgValid), 64'(mValid));
    if (rgValid && regExp.size() != 0) checkVal("regData", 64'(rgDataOut), 64'(regExp.pop_front()));
    checkVal("regHold", 64'(rgDataOut), 64'(lastReg));
  endtask

  task automatic step(input logic p, input logic q, input logic [WIDTH-1:0] d,
                      input logic f, input logic ec);
    int unsigned sz;
    logic popOk, pushOk, ovSet, unSet;
    int unsigned base;
    push = p; pop = q; dataIn = d; flush = f; errClear = ec;
    sz = modelQ.size();
    popOk  = !f && q && (sz > 0);
    pushOk = !f && p && ((sz < DEPTH) || popOk);
    ovSet  = !f && p && !pushOk;
    unSet  = !f && q && (sz == 0);
    if (f) begin
      modelQ.delete();
    end else begin
      if (popOk) begin
        lastReg = modelQ.pop_front();
        regExp.push_back(lastReg);
      end
      if (pushOk) modelQ.push_back(d);
    end
    mOv = ovSet | (mOv & !ec);
    mUn = unSet | (mUn & !ec);
    base = ec ? 0 : mHw;
    mHw = (modelQ.size() > base) ? modelQ.size() : base;
    mValid = popOk;
    @(posedge clockCore);
    #1;
    checkOutputs();
  endtask

  task automatic doReset(input logic p, input logic [WIDTH-1:0] d);
    resetCore = 1'b1; push = p; dataIn = d; pop = 1'b0; flush = 1'b0; errClear = 1'b0;
    @(posedge clockCore);
    #1;
    resetCore = 1'b0;
    modelQ.delete(); regExp.delete();
    lastReg = '0; mHw = 0; mOv = 1'b0; mUn = 1'b0; mValid = 1'b0;
    checkOutputs();
    checkVal("rstFwData", 64'(fwDataOut), 64'h0);
    checkVal("rstRegData", 64'(rgDataOut), 64'h0);
  endtask

  initial begin
    #2;
    doReset(1'b0, '0);

    // Fill to full, then a refused ninth push
    for (int unsigned i = 1; i <= 8; i++) step(1, 0, WIDTH'(i), 0, 0);
    step(1, 0, 60'h9, 0, 0);
    step(0, 0, '0, 0, 1);

    // Push into full with simultaneous pop, then drain
    step(1, 1, 60'hA, 0, 0);
    for (int unsigned i = 0; i < 8; i++) step(0, 1, '0, 0, 0);

    // Push and pop on empty: pop refused, push taken
    step(1, 1, 60'h55, 0, 0);
    step(0, 0, '0, 0, 1);
    step(0, 1, '0, 0, 0);

    // Registered-output pulses
    step(1, 0, 60'h11, 0, 0);
    step(1, 0, 60'h22, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 1, '0, 0, 0);
    step(0, 0, '0, 0, 0);
    step(0, 0, '0, 0, 0);

    // Threshold sweep 0 -> 8 -> 0
    step(0, 0, '0, 0, 1);
    for (int unsigned i = 0; i < 8; i++) step(1, 0, WIDTH'(32'h100 + i), 0, 0);
    afThr = 4'd9;
    step(0, 0, '0, 0, 0);
    afThr = 4'd6;
    for (int unsigned i = 0; i < 8; i++) step(0, 1, '0, 0, 0);

    // Fill to 5, flush with push and pop asserted
    step(0, 0, '0, 0, 1);
    for (int unsigned i = 0; i < 5; i++) step(1, 0, WIDTH'(32'h200 + i), 0, 0);
    step(1, 1, 60'hBAD, 1, 0);
    step(0, 0, '0, 0, 0);

    // Mid-stream reset
    for (int unsigned i = 0; i < 3; i++) step(1, 0, WIDTH'(32'h300 + i), 0, 0);
    doReset(1'b1, 60'h777);

    // Random traffic
    afThr = 4'(4'($urandom_range(0, 9)));
    aeThr = 4'(4'($urandom_range(0, 8)));
    for (int unsigned i = 0; i < 200; i++) begin
      step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           {28'($urandom), 32'($urandom)},
           ($urandom_range(0, 29) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule

// File: doc/reg_fifo_param.md
Name: reg_fifo_param

Overview:
Parametrised register-based synchronous FIFO. It is the next-generation replacement for the fixed-size register FIFOs in the PCIe DMA datapath.
- Depth, width and output mode are generic.
- Adds flush, a sticky error clear and a high-water occupancy monitor.
- Occupancy and threshold widths scale with depth.
- Used for descriptor, completion-header and small staging queues.

Parameters:
DEPTH, 8, number of entries; power of 2, >= 2
WIDTH, 60, data width in bits
FWFT, 1, 1 = first-word-fall-through output; 0 = registered output, data one cycle after pop
CNT_W, $clog2(DEPTH)+1, derived localparam; occupancy/threshold width (range 0..DEPTH)

Ports:
clockCore  in  1  core clock; all logic on rising edge
resetCore  in  1  synchronous, active-high reset
flush  in  1  discard all contents
push  in  1  write request
dataIn  in  WIDTH  write data
pop  in  1  read request
dataOut  out  WIDTH  read data
dataOutValid  out  1  FWFT=1: equals !empty; FWFT=0: high one cycle after an accepted pop
full  out  1  occupancy == DEPTH
empty  out  1  occupancy == 0
almostFullThreshold  in  CNT_W  almost-full level
almostEmptyThreshold  in  CNT_W  almost-empty level
almostFullFlag  out  1  occupancy >= almostFullThreshold
almostEmptyFlag  out  1  occupancy <= almostEmptyThreshold
fifoDepth  out  CNT_W  current occupancy, 0..DEPTH
highWater  out  CNT_W  maximum occupancy since reset or errClear
overrun  out  1  sticky; push refused
underrun  out  1  sticky; pop on empty
errClear  in  1  clears overrun, underrun, highWater

Behaviour:
- State: storage array, rdPtr/wrPtr (log2 DEPTH bits, natural wrap), count (CNT_W).
- All status outputs are decoded from registered state. They change the cycle after the causing edge.
- Reset (resetCore=1):
  - pointers, count, highWater = 0; storage and dataOut = 0.
  - empty=1, full=0, dataOutValid=0, overrun=0, underrun=0, almostEmptyFlag=1.
  - almostFullFlag = (almostFullThreshold==0).
- Reset has priority over every other input and aborts any operation in progress.
- Pop accept: popAcc = pop && !empty.
- Push accept: pushAcc = push && (!full || popAcc). Full with a simultaneous pop is accepted, and count is unchanged.
- Empty with simultaneous push and pop: the pop is refused (underrun), the push is accepted, and count becomes 1.
- Count update: count += pushAcc - popAcc. Never exceeds DEPTH and never goes below 0.
- Refused push: data dropped, overrun <= 1.
- Refused pop: no pointer change, underrun <= 1.
- FWFT=1:
  - dataOut = storage[rdPtr], combinational from registers.
  - The head is valid in the same cycle that empty deasserts, i.e. one cycle after the first push.
- FWFT=0:
  - On popAcc, dataOut <= storage[rdPtr] and dataOutValid <= 1 for exactly one cycle.
  - dataOut holds its last value otherwise.
- Flush:
  - Next cycle: pointers = 0, count = 0, empty = 1; dataOutValid = 0 (FWFT=0).
  - Priority over push/pop in the same cycle. Both are ignored and no error is flagged.
  - Sticky flags and highWater are unchanged.
- highWater <= max(highWater, next count) every cycle.
- errClear:
  - Clears overrun, underrun and highWater. highWater reloads with the next count.
  - If a new error occurs in the same cycle, set wins.
- Thresholds are compared unsigned and live (not latched). A threshold > DEPTH means almostFullFlag never asserts.

Decomposition:
- Package reg_fifo_pkg:
  - FIFO_MODE_FWFT=1, FIFO_MODE_REG=0.
  - Function for counter width (clog2+1).
- One sub-module, reg_fifo_ctrl, contains:
  - pointer, count and accept logic;
  - flag, sticky and highWater logic;
  - outputs: write enable, write address, read address.
- Top level holds the storage array and the output-mode generate.

Test Plan:
- DEPTH=8, WIDTH=60, FWFT=1, push 0x1..0x8 on consecutive cycles:
  - full=1 and fifoDepth=8 after the 8th edge.
  - A 9th push sets overrun=1, fifoDepth stays 8, and data 0x9 never appears.
- From full, push 0xA with pop in the same cycle:
  - dataOut was 0x1; next cycle dataOut=0x2 and fifoDepth=8.
  - Then 8 pops return 0x2..0x8, 0xA in order, with no overrun.
- Empty FIFO, pop=1 and push 0x55 together:
  - underrun=1, fifoDepth=1, next dataOut=0x55.
  - errClear clears underrun; highWater reloads to 1.
- FWFT=0, push 0x11, 0x22 then pop twice:
  - dataOutValid pulses on the cycles after each pop, carrying 0x11 then 0x22.
  - dataOut holds 0x22 afterwards.
- Thresholds AF=6, AE=2, fill 0→8→0:
  - almostEmptyFlag high for counts 0..2.
  - almostFullFlag high for 6..8.
  - highWater=8.
- Fill to 5, then flush with push asserted:
  - Next cycle fifoDepth=0, empty=1, no overrun, highWater=5.
  - Assert resetCore mid-stream: all outputs return to reset values the next cycle.
